judge_score_n: RTL and testbench

JUDGE_SCORE_N -- requirements
Module: judge_score_n

---
 rtl/judge_score_n.sv | 217 +++++++++++++++++++++
 tb/tb_judge_score_n.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/judge_score_n.sv
`default_nettype none
// ============================================================================
// Module      : judge_score_n
// Description : Collects NJ judge scores, optionally drops one maximum and one
//               minimum, and computes floor(10*T/D) with a bit-serial
//               restoring divider. The result is shown as "XX.X" on a
//               4-digit multiplexed 7-segment display. While collecting,
//               the display shows how many scores have been accepted.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset
//               scorein  - current judge score (0 is ignored)
//               submit   - level strobe; each rising edge offers scorein
//               clear    - synchronous pulse; starts a new round
//               seg      - segments {dp,g,f,e,d,c,b,a}, active high
//               sel      - one-hot digit select, sel[0] = rightmost
//               done     - high while a valid result is displayed
// Revision    : 1.0 - initial release
// ============================================================================
module judge_score_n #(
    parameter int NJ   = 7,
    parameter int SW   = 4,
    parameter int DROP = 1,
    parameter int SCAN = 50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] scorein,
    input  logic          submit,
    input  logic          clear,
    output logic [7:0]    seg,
    output logic [3:0]    sel,
    output logic          done
);

    localparam int SMAX = (1 << SW) - 1;
    localparam int SUMW = $clog2(NJ * SMAX + 1);
    localparam int DW   = $clog2(10 * NJ * SMAX + 1);
    localparam int RW   = DW - 1;
    localparam int CW   = $clog2(NJ + 1);
    localparam int STW  = $clog2(DW + 1);
    localparam int SCW  = $clog2(SCAN + 1);

    localparam logic [DW-1:0]  c_divisor   = DW'((DROP != 0) ? NJ - 2 : NJ);
    localparam logic [DW-1:0]  c_ten       = DW'(10);
    localparam logic [CW-1:0]  c_nj        = CW'(NJ);
    localparam logic [STW-1:0] c_last_step = STW'(DW - 1);
    localparam logic [SCW-1:0] c_scan_last = SCW'(SCAN - 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_CALC    = 2'd1;
    localparam logic [1:0] S_SHOW    = 2'd2;

    logic [1:0]      r_state, w_state_nxt;
    logic            r_sub_d;
    logic            r_armed;
    logic [CW-1:0]   r_count;
    logic [SUMW-1:0] r_sum;
    logic [SW-1:0]   r_max, r_min;
    logic [DW-1:0]   r_div;
    logic [RW-1:0]   r_rem;
    logic [DW-1:0]   r_quot;
    logic [STW-1:0]  r_step;
    logic [SCW-1:0]  r_scan;
    logic [1:0]      r_digit;

    logic            w_accept;
    logic [SUMW-1:0] w_t;
    logic [DW-1:0]   w_num;
    logic [DW-1:0]   w_trial;
    logic            w_ge;

    // r_armed stays low after reset until submit has been seen low, so a
    // submit held through reset is not taken as a fresh edge.
    assign w_accept = (r_state == S_COLLECT) && submit && !r_sub_d && r_armed
                      && (scorein != '0) && (r_count != c_nj) && !clear;

    assign w_t   = (DROP != 0) ? (r_sum - SUMW'(r_max) - SUMW'(r_min)) : r_sum;
    assign w_num = DW'(w_t) * c_ten;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor when it fits.
    assign w_trial = {r_rem, r_div[DW-1]};
    assign w_ge    = (w_trial >= c_divisor);

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_COLLECT;
        end else begin
            case (r_state)
                S_COLLECT: if (r_count == c_nj)       w_state_nxt = S_CALC;
                S_CALC:    if (r_step == c_last_step) w_state_nxt = S_SHOW;
                S_SHOW:    w_state_nxt = S_SHOW;
                default:   w_state_nxt = S_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sub_d <= 1'b0;
            r_armed <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
            r_max   <= '0;
            r_min   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            r_step  <= '0;
        end else begin
            r_sub_d <= submit;
            if (!submit) begin
                r_armed <= 1'b1;
            end
            if (clear) begin
                r_count <= '0;
                r_sum   <= '0;
                r_max   <= '0;
                r_min   <= '0;
                r_div   <= '0;
                r_rem   <= '0;
                r_quot  <= '0;
                r_step  <= '0;
            end else begin
                case (r_state)
                    S_COLLECT: begin
                        if (w_accept) begin
                            r_count <= r_count + 1'b1;
                            r_sum   <= r_sum + SUMW'(scorein);
                            if ((r_count == '0) || (scorein > r_max)) r_max <= scorein;
                            if ((r_count == '0) || (scorein < r_min)) r_min <= scorein;
                        end
                        if (w_state_nxt == S_CALC) begin
                            r_div  <= w_num;
                            r_rem  <= '0;
                            r_quot <= '0;
                            r_step <= '0;
                        end
                    end
                    S_CALC: begin
                        r_div  <= r_div << 1;
                        r_rem  <= RW'(w_ge ? (w_trial - c_divisor) : w_trial);
                        r_quot <= {r_quot[DW-2:0], w_ge};
                        r_step <= r_step + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Free-running digit scan, independent of the round state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan  <= '0;
            r_digit <= 2'd0;
        end else if (r_scan == c_scan_last) begin
            r_scan  <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_scan  <= r_scan + 1'b1;
        end
    end

    function automatic logic [7:0] f_dec7(input logic [3:0] v);
        case (v)
            4'd0:    f_dec7 = 8'h3F;
            4'd1:    f_dec7 = 8'h06;
            4'd2:    f_dec7 = 8'h5B;
            4'd3:    f_dec7 = 8'h4F;
            4'd4:    f_dec7 = 8'h66;
            4'd5:    f_dec7 = 8'h6D;
            4'd6:    f_dec7 = 8'h7D;
            4'd7:    f_dec7 = 8'h07;
            4'd8:    f_dec7 = 8'h7F;
            4'd9:    f_dec7 = 8'h6F;
            default: f_dec7 = 8'h00;
        endcase
    endfunction

    always_comb begin
        sel = 4'b0001 << r_digit;
        seg = 8'h00;
        case (r_state)
            S_COLLECT: begin
                case (r_digit)
                    2'd0: seg = f_dec7(4'(32'(r_count) % 32'd10));
                    2'd1: if (32'(r_count) >= 32'd10) seg = f_dec7(4'(32'(r_count) / 32'd10));
                    default: seg = 8'h00;
                endcase
            end
            S_SHOW: begin
                case (r_digit)
                    2'd0: seg = f_dec7(4'(32'(r_quot) % 32'd10));
                    2'd1: seg = f_dec7(4'((32'(r_quot) / 32'd10) % 32'd10)) | 8'h80;
                    2'd2: if (32'(r_quot) >= 32'd100) seg = f_dec7(4'(32'(r_quot) / 32'd100));
                    default: seg = 8'h00;
                endcase
            end
            default: seg = 8'h00;
        endcase
    end

    assign done = (r_state == S_SHOW);

endmodule
`default_nettype wire

// File: tb/tb_judge_score_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_judge_score_n
// Description : Self-checking bench for judge_score_n. Three instances share
//               one stimulus stream: NJ=7/DROP=1, NJ=6/DROP=1, NJ=6/DROP=0.
//               The displayed digits are captured over a full scan and
//               compared with values from a sort-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_judge_score_n;

    localparam int SCAN = 2;
    localparam int DW7  = 11;   // bit width of 10*7*15 = 1050

    logic clk = 1'b0;
    logic rst, submit, clear;
    logic [3:0] scorein;
    logic [2:0][7:0] seg_v;
    logic [2:0][3:0] sel_v;
    logic [2:0]      done_v;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    judge_score_n #(.NJ(7), .SW(4), .DROP(1), .SCAN(SCAN)) u_dut7 (
        .clk(clk), .rst(rst), .scorein(scorein), .submit(submit), .clear(clear),
        .seg(seg_v[0]), .sel(sel_v[0]), .done(done_v[0]));
    judge_score_n #(.NJ(6), .SW(4), .DROP(1), .SCAN(SCAN)) u_dut6 (
        .clk(clk), .rst(rst), .scorein(scorein), .submit(submit), .clear(clear),
        .seg(seg_v[1]), .sel(sel_v[1]), .done(done_v[1]));
    judge_score_n #(.NJ(6), .SW(4), .DROP(0), .SCAN(SCAN)) u_dut6n (
        .clk(clk), .rst(rst), .scorein(scorein), .submit(submit), .clear(clear),
        .seg(seg_v[2]), .sel(sel_v[2]), .done(done_v[2]));

    typedef struct {
        int s[7];
        int a7;
        int a6;
        int a6n;
    } vec_t;
    vec_t tbl[5];

    function automatic logic [7:0] enc(input int d);
        logic [7:0] t [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        return t[d];
    endfunction

    function automatic logic [31:0] exp_show(input int a);
        logic [7:0] d2;
        d2 = (a / 100 == 0) ? 8'h00 : enc(a / 100);
        return {8'h00, d2, enc((a / 10) % 10) | 8'h80, enc(a % 10)};
    endfunction

    function automatic logic [31:0] exp_collect(input int cnt);
        logic [7:0] d1;
        d1 = (cnt < 10) ? 8'h00 : enc(cnt / 10);
        return {16'h0000, d1, enc(cnt % 10)};
    endfunction

    // Average of the first n nonzero scores: sort, optionally trim the two
    // ends, then truncate 10*sum/len.
    function automatic int ref_avg(input int q[$], input int n, input bit drop);
        int v[$];
        int sum;
        foreach (q[i]) if (q[i] != 0 && v.size() < n) v.push_back(q[i]);
        v.sort();
        if (drop) begin
            void'(v.pop_front());
            void'(v.pop_back());
        end
        sum = 0;
        foreach (v[i]) sum += v[i];
        return (10 * sum) / v.size();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int s, input int hold);
        scorein = 4'(s);
        submit  = 1'b1;
        repeat (hold) tick();
        submit = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    // Captures the four digits of instance k over one full scan.
    task automatic capture(input string name, input int k, output logic [31:0] d);
        logic [3:0] seen;
        logic       bad;
        d = '0; seen = '0; bad = 1'b0;
        for (int i = 0; i < 4 * SCAN; i++) begin
            @(negedge clk);
            case (sel_v[k])
                4'b0001: d[7:0]   = seg_v[k];
                4'b0010: d[15:8]  = seg_v[k];
                4'b0100: d[23:16] = seg_v[k];
                4'b1000: d[31:24] = seg_v[k];
                default: bad = 1'b1;
            endcase
            seen |= sel_v[k];
        end
        check({name, "_sel"}, {27'd0, bad, seen}, 32'h0000_000F);
    endtask

    task automatic round(input string name, input int sc[$],
                         input int a7, input int a6, input int a6n, input bit timing);
        int acc, cyc;
        logic [31:0] d;
        do_clear();
        acc = 0;
        foreach (sc[i]) begin
            if (sc[i] != 0 && acc == 6) begin
                scorein = 4'(sc[i]);
                submit  = 1'b1;
                tick();
                submit = 1'b0;
                cyc = 0;
                while (!done_v[0] && cyc < 100) begin
                    tick();
                    cyc++;
                end
                if (timing) check({name, "_latency"}, 32'(cyc), 32'(DW7 + 1));
                else        check({name, "_done"}, {31'd0, done_v[0]}, 32'd1);
                acc++;
            end else begin
                put(sc[i], 1 + int'($urandom_range(2)));
                if (sc[i] != 0) acc++;
            end
        end
        capture({name, "_nj7"}, 0, d);
        check({name, "_nj7"}, d, exp_show(a7));
        capture({name, "_nj6"}, 1, d);
        check({name, "_nj6"}, d, exp_show(a6));
        capture({name, "_nj6_nodrop"}, 2, d);
        check({name, "_nj6_nodrop"}, d, exp_show(a6n));
        // An edge while showing must leave the result alone.
        put(5, 1);
        capture({name, "_hold"}, 0, d);
        check({name, "_hold"}, d, exp_show(a7));
    endtask

    task automatic set_vec(input int i, input int s0, input int s1, input int s2,
                           input int s3, input int s4, input int s5, input int s6,
                           input int a7, input int a6, input int a6n);
        tbl[i].s = '{s0, s1, s2, s3, s4, s5, s6};
        tbl[i].a7 = a7; tbl[i].a6 = a6; tbl[i].a6n = a6n;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  prev;
        int run, scan_bad;
        int q[$];

        // Expected averages: NJ=7 drops one max/min of all seven; NJ=6
        // instances see only the first six scores.
        set_vec(0, 1, 2, 3, 4, 5, 6, 7,    40,  35,  35);
        set_vec(1, 15, 15, 15, 15, 15, 15, 15, 150, 150, 150);
        set_vec(2, 3, 5, 5, 6, 8, 9, 10,   66,  60,  60);
        set_vec(3, 1, 2, 3, 3, 5, 6, 4,    34,  32,  33);
        set_vec(4, 9, 9, 9, 2, 2, 9, 9,    76,  72,  66);

        rst = 1'b1; clear = 1'b0; submit = 1'b1; scorein = 4'd5;
        repeat (3) tick();
        check("reset_seg", {8'h0, seg_v[0], seg_v[1], seg_v[2]}, 32'h003F_3F3F);
        check("reset_sel", {20'h0, sel_v[0], sel_v[1], sel_v[2]}, 32'h0000_0111);
        check("reset_done", {29'd0, done_v}, 32'd0);

        // submit held through reset must not count
        rst = 1'b0;
        repeat (3) tick();
        capture("held_submit", 0, d);
        check("held_submit", d, exp_collect(0));
        submit = 1'b0; tick();
        submit = 1'b1; tick();
        submit = 1'b0; tick();
        capture("rearmed_submit", 0, d);
        check("rearmed_submit", d, exp_collect(1));

        // scan order 0->1->2->3 with SCAN-cycle dwell
        scan_bad = 0; run = 0;
        @(negedge clk);
        prev = sel_v[0];
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (sel_v[0] == prev) run++;
            else begin
                if (sel_v[0] != {prev[2:0], prev[3]}) scan_bad++;
                if (run != 0 && run + 1 != SCAN) scan_bad++;
                run = 0;
                prev = sel_v[0];
            end
        end
        check("scan_order", 32'(scan_bad), 32'd0);
        tick();

        // table vectors
        for (int i = 0; i < 5; i++) begin
            q = {};
            foreach (tbl[i].s[j]) q.push_back(tbl[i].s[j]);
            round($sformatf("vec%0d", i), q, tbl[i].a7, tbl[i].a6, tbl[i].a6n, 1'b1);
        end

        // zero score and long submit
        do_clear();
        put(0, 1);
        capture("zero_score", 0, d);
        check("zero_score", d, exp_collect(0));
        put(9, 40);
        capture("long_submit", 0, d);
        check("long_submit", d, exp_collect(1));
        put(3, 1);
        capture("second_score", 0, d);
        check("second_score", d, exp_collect(2));

        // clear coincident with the 5th edge
        do_clear();
        for (int i = 0; i < 4; i++) put(i + 2, 1);
        scorein = 4'd6; submit = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; submit = 1'b0;
        tick();
        capture("clear_wins", 0, d);
        check("clear_wins", d, exp_collect(0));
        check("clear_wins_done", {31'd0, done_v[0]}, 32'd0);
        put(2, 1);
        capture("after_clear", 0, d);
        check("after_clear", d, exp_collect(1));

        // reset in the middle of CALC
        do_clear();
        for (int i = 0; i < 7; i++) put(i + 1, 1);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_calc_sel", {28'd0, sel_v[0]}, 32'h1);
        check("rst_calc_seg", {24'd0, seg_v[0]}, 32'h3F);
        check("rst_calc_done", {29'd0, done_v}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        repeat (20) tick();
        check("rst_calc_no_result", {29'd0, done_v}, 32'd0);
        capture("rst_calc_disp", 0, d);
        check("rst_calc_disp", d, exp_collect(0));

        // randomized rounds against the reference model
        for (int r = 0; r < 25; r++) begin
            q = {};
            for (int i = 0; i < 7; i++) begin
                if ($urandom_range(4) == 0) q.push_back(0);
                q.push_back(int'($urandom_range(15, 1)));
            end
            round($sformatf("rnd%0d", r), q,
                  ref_avg(q, 7, 1'b1), ref_avg(q, 6, 1'b1), ref_avg(q, 6, 1'b0), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
